// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file with one byte-strobed write port
// and two independent registered read ports with write-first bypass.
// It also provides sticky per-register write locks, a sequenced clear sweep
// that leaves locked registers untouched, and a pulse for each rejected write.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_strb  write request with byte enables
//   rd0_en/rd0_addr -> rd0_data/rd0_valid   read port 0 (1-cycle latency)
//   rd1_en/rd1_addr -> rd1_data/rd1_valid   read port 1 (1-cycle latency)
//   lock_en/lock_addr           set the sticky lock bit of one register
//   clr_req                     start a clear sweep
//   busy                        high while a clear sweep is running
//   wr_err                      one-cycle pulse after a rejected write
module regfile_2r1w #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_strb,
  input  logic                 rd0_en,
  input  logic [ADDR_W-1:0]    rd0_addr,
  output logic [WIDTH-1:0]     rd0_data,
  output logic                 rd0_valid,
  input  logic                 rd1_en,
  input  logic [ADDR_W-1:0]    rd1_addr,
  output logic [WIDTH-1:0]     rd1_data,
  output logic                 rd1_valid,
  input  logic                 lock_en,
  input  logic [ADDR_W-1:0]    lock_addr,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 wr_err
);

  localparam int NBYTES = WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0]     lock_q, lock_d;
  logic [WIDTH-1:0]     rd0_data_q, rd0_data_d;
  logic [WIDTH-1:0]     rd1_data_q, rd1_data_d;
  logic                 rd0_valid_q, rd0_valid_d;
  logic                 rd1_valid_q, rd1_valid_d;
  logic                 busy_q, busy_d;
  logic                 wr_err_q, wr_err_d;

  logic wr_in_range, rd0_in_range, rd1_in_range, lock_in_range;
  logic wr_acc;

  always_comb begin
    wr_in_range   = {1'b0, wr_addr}   < DEPTH_L;
    rd0_in_range  = {1'b0, rd0_addr}  < DEPTH_L;
    rd1_in_range  = {1'b0, rd1_addr}  < DEPTH_L;
    lock_in_range = {1'b0, lock_addr} < DEPTH_L;

    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    lock_d  = lock_q;

    // Lock is checked against the current lock bits, so a lock issued in the
    // same cycle as a write to that register only blocks later writes.
    wr_acc = 1'b0;
    if (wr_en && wr_in_range && (state_q == IDLE)) begin
      wr_acc = !lock_q[wr_addr];
    end

    if (wr_acc) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (wr_strb[b]) begin
          mem_d[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (!lock_q[idx_q]) begin
          mem_d[idx_q] = '0;
        end
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (lock_en && lock_in_range) begin
      lock_d[lock_addr] = 1'b1;
    end

    wr_err_d = wr_en && !wr_acc;
    busy_d   = (state_d == CLEAR);

    // Reads sample the next-state array, which gives write-first bypass and
    // makes a read of the register being swept return its cleared value.
    rd0_data_d  = rd0_data_q;
    rd0_valid_d = rd0_en;
    if (rd0_en) begin
      rd0_data_d = rd0_in_range ? mem_d[rd0_addr] : '0;
    end

    rd1_data_d  = rd1_data_q;
    rd1_valid_d = rd1_en;
    if (rd1_en) begin
      rd1_data_d = rd1_in_range ? mem_d[rd1_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lock_q      <= '0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lock_q      <= lock_d;
      rd0_data_q  <= rd0_data_d;
      rd1_data_q  <= rd1_data_d;
      rd0_valid_q <= rd0_valid_d;
      rd1_valid_q <= rd1_valid_d;
      busy_q      <= busy_d;
      wr_err_q    <= wr_err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd0_data  = rd0_data_q;
  assign rd1_data  = rd1_data_q;
  assign rd0_valid = rd0_valid_q;
  assign rd1_valid = rd1_valid_q;
  assign busy      = busy_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed bench for regfile_2r1w with a 16x16 instance and
// a 12-entry instance (5-bit address) for out-of-range address handling.
module tb_regfile_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 16 x 16 instance
  logic        wr_en, rd0_en, rd1_en, lock_en, clr_req;
  logic [3:0]  wr_addr, rd0_addr, rd1_addr, lock_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_strb;
  logic [15:0] rd0_data, rd1_data;
  logic        rd0_valid, rd1_valid, busy, wr_err;

  // 12-entry instance
  logic        s_wr_en, s_rd0_en, s_rd1_en, s_lock_en, s_clr_req;
  logic [4:0]  s_wr_addr, s_rd0_addr, s_rd1_addr, s_lock_addr;
  logic [15:0] s_wr_data;
  logic [1:0]  s_wr_strb;
  logic [15:0] s_rd0_data, s_rd1_data;
  logic        s_rd0_valid, s_rd1_valid, s_busy, s_wr_err;

  regfile_2r1w #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
    .lock_en(lock_en), .lock_addr(lock_addr), .clr_req(clr_req),
    .busy(busy), .wr_err(wr_err)
  );

  regfile_2r1w #(.WIDTH(16), .DEPTH(12), .ADDR_W(5)) u_dut12 (
    .clk(clk), .rst(rst),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_strb(s_wr_strb),
    .rd0_en(s_rd0_en), .rd0_addr(s_rd0_addr), .rd0_data(s_rd0_data), .rd0_valid(s_rd0_valid),
    .rd1_en(s_rd1_en), .rd1_addr(s_rd1_addr), .rd1_data(s_rd1_data), .rd1_valid(s_rd1_valid),
    .lock_en(s_lock_en), .lock_addr(s_lock_addr), .clr_req(s_clr_req),
    .busy(s_busy), .wr_err(s_wr_err)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] model [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd0_en = 1'b0; rd0_addr = '0; rd1_en = 1'b0; rd1_addr = '0;
    lock_en = 1'b0; lock_addr = '0; clr_req = 1'b0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_wr_strb = '0;
    s_rd0_en = 1'b0; s_rd0_addr = '0; s_rd1_en = 1'b0; s_rd1_addr = '0;
    s_lock_en = 1'b0; s_lock_addr = '0; s_clr_req = 1'b0;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read0(input logic [3:0] a);
    rd0_en = 1'b1; rd0_addr = a;
    tick();
    rd0_en = 1'b0;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0]  = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b0;
    #12;
    check("reset_rd0_data", 32'(rd0_data), 32'h0);
    check("reset_rd0_valid", 32'(rd0_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_wr_err", 32'(wr_err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Basic write then read with one-cycle latency.
    write(4'd3, 16'hA5A5, 2'b11);
    check("wr3_err", 32'(wr_err), 32'h0);
    rd0_en = 1'b1; rd0_addr = 4'd3;
    tick();
    rd0_en = 1'b0;
    check("rd3_data", 32'(rd0_data), 32'hA5A5);
    check("rd3_valid", 32'(rd0_valid), 32'h1);
    tick();
    check("rd_valid_drop", 32'(rd0_valid), 32'h0);
    check("rd_data_hold", 32'(rd0_data), 32'hA5A5);

    // All-zero strobe is an accepted no-op.
    write(4'd3, 16'h0000, 2'b00);
    check("strb0_no_err", 32'(wr_err), 32'h0);
    read0(4'd3);
    check("strb0_unchanged", 32'(rd0_data), 32'hA5A5);

    // Write-first bypass with partial strobe.
    write(4'd5, 16'h1234, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hFFFF; wr_strb = 2'b01;
    rd1_en = 1'b1; rd1_addr = 4'd5;
    tick();
    wr_en = 1'b0; rd1_en = 1'b0;
    check("bypass_rd1", 32'(rd1_data), 32'h12FF);
    read0(4'd5);
    check("merged_rd0", 32'(rd0_data), 32'h12FF);

    // Locks.
    write(4'd2, 16'h2222, 2'b11);
    lock_en = 1'b1; lock_addr = 4'd2;
    tick();
    lock_en = 1'b0;
    write(4'd2, 16'hBEEF, 2'b11);
    check("lock_wr_err", 32'(wr_err), 32'h1);
    tick();
    check("lock_err_pulse", 32'(wr_err), 32'h0);
    read0(4'd2);
    check("lock_unchanged", 32'(rd0_data), 32'h2222);
    // Write and lock on the same cycle: write lands, later write rejected.
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444; wr_strb = 2'b11;
    lock_en = 1'b1; lock_addr = 4'd4;
    tick();
    wr_en = 1'b0; lock_en = 1'b0;
    check("wr_lock_same_err", 32'(wr_err), 32'h0);
    write(4'd4, 16'h5555, 2'b11);
    check("wr_after_lock_err", 32'(wr_err), 32'h1);
    read0(4'd4);
    check("wr_lock_same_data", 32'(rd0_data), 32'h4444);

    // Out-of-range addresses on the 12-entry instance.
    s_wr_en = 1'b1; s_wr_addr = 5'd20; s_wr_data = 16'h9999; s_wr_strb = 2'b11;
    tick();
    s_wr_en = 1'b0;
    check("oor_wr_err", 32'(s_wr_err), 32'h1);
    s_rd0_en = 1'b1; s_rd0_addr = 5'd20;
    tick();
    s_rd0_en = 1'b0;
    check("oor_wr_err_pulse", 32'(s_wr_err), 32'h0);
    check("oor_rd_data", 32'(s_rd0_data), 32'h0);
    check("oor_rd_valid", 32'(s_rd0_valid), 32'h1);
    s_wr_en = 1'b1; s_wr_addr = 5'd11; s_wr_data = 16'hCAFE; s_wr_strb = 2'b11;
    tick();
    check("last_wr_err", 32'(s_wr_err), 32'h0);
    s_wr_addr = 5'd12;
    s_rd1_en = 1'b1; s_rd1_addr = 5'd11;
    tick();
    s_wr_en = 1'b0; s_rd1_en = 1'b0;
    check("depth_wr_err", 32'(s_wr_err), 32'h1);
    check("last_rd_data", 32'(s_rd1_data), 32'hCAFE);

    // Clear sweep: reset first so earlier locks do not interfere.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    for (int a = 0; a < 16; a++) write(4'(a), 16'h00FF, 2'b11);
    lock_en = 1'b1; lock_addr = 4'd7;
    tick();
    lock_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int j = 0; j < 16; j++) begin
      check($sformatf("sweep_busy_%0d", j), 32'(busy), 32'h1);
      rd0_en = 1'b1; rd0_addr = 4'(j);
      if (j == 4) begin
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1234; wr_strb = 2'b11;
      end
      if (j == 10) clr_req = 1'b1;
      tick();
      wr_en = 1'b0; clr_req = 1'b0; rd0_en = 1'b0;
      check($sformatf("sweep_rd_%0d", j), 32'(rd0_data), (j == 7) ? 32'h00FF : 32'h0);
      if (j == 4) check("sweep_wr_err", 32'(wr_err), 32'h1);
    end
    check("sweep_done_busy", 32'(busy), 32'h0);
    for (int a = 0; a < 16; a++) begin
      read0(4'(a));
      check($sformatf("post_sweep_%0d", a), 32'(rd0_data), (a == 7) ? 32'h00FF : 32'h0);
    end

    // Reset in the middle of a sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    read0(4'd7);
    check("mid_sweep_busy", 32'(busy), 32'h1);
    check("mid_sweep_rd7", 32'(rd0_data), 32'h00FF);
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rd0_data", 32'(rd0_data), 32'h0);
    check("rst_rd0_valid", 32'(rd0_valid), 32'h0);
    #2;
    rst = 1'b1;
    tick();
    check("after_rst_busy", 32'(busy), 32'h0);
    read0(4'd7);
    check("after_rst_reg7", 32'(rd0_data), 32'h0);
    write(4'd7, 16'h7777, 2'b11);
    check("unlock_wr_err", 32'(wr_err), 32'h0);
    read0(4'd7);
    check("unlock_wr_data", 32'(rd0_data), 32'h7777);

    // Random writes while both ports watch addresses 0 and 15.
    for (int a = 0; a < 16; a++) model[a] = '0;
    model[7] = 16'h7777;
    for (int c = 0; c < 20; c++) begin
      logic [15:0] e0, e1;
      wr_en   = 1'($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       wr_addr = 4'd0;
        1:       wr_addr = 4'd15;
        default: wr_addr = 4'($urandom_range(0, 15));
      endcase
      wr_data = 16'($urandom);
      wr_strb = 2'($urandom_range(0, 3));
      rd0_en = 1'b1; rd0_addr = 4'd0;
      rd1_en = 1'b1; rd1_addr = 4'd15;
      if (wr_en) model[wr_addr] = merge(model[wr_addr], wr_data, wr_strb);
      e0 = model[0];
      e1 = model[15];
      tick();
      check($sformatf("rand_rd0_%0d", c), 32'(rd0_data), 32'(e0));
      check($sformatf("rand_rd1_%0d", c), 32'(rd1_data), 32'(e1));
      check($sformatf("rand_valid_%0d", c), 32'({rd0_valid, rd1_valid}), 32'h3);
    end
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file, the successor to the single-port 8x16 register file. It has one byte-strobed write port and two independent registered read ports with write-first bypass. It adds per-register write locks and a sequenced clear engine, and flags illegal writes. It sits between the command decoder and the datapath as the main configuration/scratch storage.

## Interface
- WIDTH, 16: data width in bits; must be a multiple of 8.
- DEPTH, 16: number of registers, 2..256; need not be a power of two.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W >= DEPTH.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- wr_strb  in  WIDTH/8  byte enables; bit i gates wr_data[8i+7:8i].
- rd0_en / rd1_en  in  1  read request, port 0 / port 1.
- rd0_addr / rd1_addr  in  ADDR_W  read address.
- rd0_data / rd1_data  out  WIDTH  registered read data.
- rd0_valid / rd1_valid  out  1  high one cycle after an accepted read.
- lock_en  in  1  set the lock bit of lock_addr.
- lock_addr  in  ADDR_W  register to lock.
- clr_req  in  1  start a clear sweep.
- busy  out  1  clear sweep in progress.
- wr_err  out  1  one-cycle pulse for a rejected write.

## Operation
- Storage is DEPTH x WIDTH registers plus DEPTH lock bits.
- Reset (async assert) sets:
  - all registers, lock bits, rdN_data and rdN_valid to 0;
  - busy and wr_err to 0;
  - the FSM to IDLE.
- Write rules:
  - A write is accepted when wr_en=1, wr_addr<DEPTH, the target is unlocked and the FSM is IDLE.
  - An accepted write updates only the bytes with wr_strb=1; wr_strb=0 on all bytes is accepted as a no-op (no error).
  - A write is rejected when wr_addr>=DEPTH, the target is locked, or the FSM is CLEAR. A rejected write leaves storage unchanged and pulses wr_err the next cycle.
- Read rules:
  - Each port is independent; both may target the same address.
  - rdN_data is loaded only when rdN_en=1 and holds otherwise.
  - An address >= DEPTH returns 0 with rdN_valid=1.
  - Reads are served in both IDLE and CLEAR.
- Bypass (write-first): if an accepted write and a read target the same address in the same cycle, rdN_data returns the merged value (strobed new bytes, old bytes elsewhere).
- Lock rules:
  - lock_en with lock_addr<DEPTH sets that lock bit; out-of-range lock_addr is ignored.
  - Locks are sticky and cleared only by reset.
  - A write and a lock on the same address in the same cycle: the write is applied and the lock takes effect from the next cycle.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req=1, with the index counter loaded to 0.
  - In CLEAR, each cycle zeroes register[idx] if unlocked (locked registers retain their value), then increments idx.
  - CLEAR -> IDLE in the cycle that idx=DEPTH-1 is processed.
  - clr_req while in CLEAR is ignored.
- Simultaneous write and clr_req in IDLE: the write is accepted, then the sweep zeroes that register in due course.
- A read bypass during CLEAR reflects the zeroing of the register being cleared that cycle.

## Timing
- Read latency is 1 cycle: request at edge N, data and valid after edge N+1. rdN_valid is a single-cycle pulse per request; back-to-back requests keep it high.
- Writes are visible to a non-bypassed read issued the following cycle.
- busy is high for exactly DEPTH cycles, starting the cycle after clr_req is sampled.
- wr_err pulses for 1 cycle, one cycle after the rejected request.
- Reset deasserted mid-sweep leaves the FSM in IDLE and all registers 0.
- No combinational path from any input to any output.

## Test plan
Defaults: WIDTH=16, DEPTH=16 unless stated.
- Write 0xA5A5 to addr 3 with strb=11; read port 0 addr 3 next cycle -> rd0_data=0xA5A5 and rd0_valid=1 one cycle after the request.
- With reg5=0x1234, write 0xFFFF strb=01 to addr 5 while rd1 reads addr 5 the same cycle -> rd1_data=0x12FF (bypass).
- lock_en addr 2, then write 0xBEEF to addr 2 -> wr_err pulses once and reg2 is unchanged. Write addr 20 with DEPTH=12 -> wr_err pulses; read addr 20 -> 0.
- Fill all regs with 0x00FF, lock addr 7, assert clr_req for 1 cycle:
  - busy is high for 16 cycles;
  - a write at cycle 4 of the sweep -> wr_err;
  - after the sweep all regs read 0 except reg7=0x00FF.
- Reset asserted at cycle 5 of a sweep -> busy=0, all regs and locks 0 immediately; after release, a write to previously locked addr 7 succeeds.
- Both ports read addrs 0 and 15 every cycle for 20 cycles during random writes -> data matches the reference model each cycle.
